core_sequencer: RTL

Parametrised multi-cycle control sequencer for the RISC-V core, replacing the fixed-wait-state FSM in the top level. It owns the program counter, sequences fetch/decode/execute/memory/writeback, and talks to memory through a variable-latency request/ready handshake with a timeout. It adds precise traps (decode error, bus timeout, misaligned PC), a sticky halt, single-step debug mode and a retired-instruction counter. Datapath (decoder, register file, ALU, memory) stays outside; this block drives only strobes and the PC.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/core_sequencer_if.sv | 10 +
 rtl/core_sequencer_mem_wait_timer.sv | 22 ++
 rtl/core_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared state encodings, trap causes and strobe bundle for the core sequencer.
package core_pkg;
    localparam int WORD_SIZE_DEF = 32;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EXECUTE = 4'd3,
        ST_MEM     = 4'd4,
        ST_WB      = 4'd5,
        ST_PAUSE   = 4'd6,
        ST_HALT    = 4'd9,
        ST_TRAP    = 4'd14
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_DECODE = 2'd1,
        CAUSE_BUS    = 2'd2,
        CAUSE_ALIGN  = 2'd3
    } cause_e;

    typedef struct packed {
        logic mem_req;
        logic mem_we;
        logic addr_sel;
        logic ir_load;
        logic operand_load;
    } strobe_t;

    // Strobes are registered from the next state so they are glitch-free Moore outputs.
    function automatic strobe_t strobes_of(state_e s, logic store);
        return '{mem_req:      (s == ST_FETCH) || (s == ST_MEM),
                 mem_we:       (s == ST_MEM) && store,
                 addr_sel:     (s == ST_MEM),
                 ir_load:      (s == ST_DECODE),
                 operand_load: (s == ST_EXECUTE)};
    endfunction
endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: request/ready memory handshake between the sequencer and memory.
interface core_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, mem_we, addr_sel, input mem_ready);
    modport slave  (input mem_req, mem_we, addr_sel, output mem_ready);
endinterface

// File: rtl/core_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles; expired means the last allowed cycle is now.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(MEM_TIMEOUT);

    logic [CW-1:0] cnt_q;

    assign expired_o = cnt_q == CW'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && !expired_o) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/mem/writeback control with PC, traps and debug step.
module core_sequencer
    import core_pkg::*;
#(
    parameter int                   WORD_SIZE   = WORD_SIZE_DEF,
    parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
    parameter int                   MEM_TIMEOUT = 16,
    parameter int                   COUNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 step_mode_i,
    input  logic                 step_i,
    input  logic                 is_load_i,
    input  logic                 is_store_i,
    input  logic                 writes_rd_i,
    input  logic                 is_halt_i,
    input  logic                 decode_error_i,
    input  logic                 pc_redirect_i,
    input  logic [WORD_SIZE-1:0] pc_target_i,
    core_sequencer_if.master     mem,
    output logic [3:0]           state_o,
    output logic [WORD_SIZE-1:0] pc_o,
    output logic                 ir_load_o,
    output logic                 operand_load_o,
    output logic                 reg_we_o,
    output logic [COUNT_W-1:0]   retire_count_o,
    output logic                 halted_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o
);
    state_e               state_q, state_d;
    cause_e               cause_q, cause_d;
    strobe_t              strb_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [COUNT_W-1:0]   retire_q;
    logic                 expired;
    logic                 misaligned;
    logic [WORD_SIZE-1:0] pc_next;

    assign misaligned = pc_redirect_i && (pc_target_i[1:0] != 2'b00);
    assign pc_next    = pc_redirect_i ? pc_target_i : pc_q + WORD_SIZE'(4);

    // Timer clears whenever no request is outstanding, so it restarts on each FETCH/MEM entry.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!strb_q.mem_req),
        .en_i     (strb_q.mem_req && !mem.mem_ready),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE:    state_d = start_i ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (mem.mem_ready) state_d = ST_DECODE;
                else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (is_halt_i) state_d = ST_HALT;
                else if (decode_error_i) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DECODE;
                end
                else state_d = (is_load_i || is_store_i) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (mem.mem_ready) state_d = ST_WB;
                else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            ST_WB: begin
                if (misaligned) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ALIGN;
                end
                else state_d = step_mode_i ? ST_PAUSE : ST_FETCH;
            end
            ST_PAUSE:   state_d = (step_i || !step_mode_i) ? ST_FETCH : ST_PAUSE;
            ST_HALT, ST_TRAP: state_d = state_q;
            default: begin
                state_d = ST_TRAP;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cause_q  <= CAUSE_NONE;
            strb_q   <= '0;
            pc_q     <= RESET_PC;
            retire_q <= '0;
        end
        else begin
            state_q <= state_d;
            cause_q <= cause_d;
            strb_q  <= strobes_of(state_d, is_store_i);
            if (state_q == ST_WB && !misaligned) begin
                pc_q     <= pc_next;
                retire_q <= retire_q + COUNT_W'(1);
            end
        end
    end

    assign mem.mem_req     = strb_q.mem_req;
    assign mem.mem_we      = strb_q.mem_we;
    assign mem.addr_sel    = strb_q.addr_sel;
    assign ir_load_o       = strb_q.ir_load;
    assign operand_load_o  = strb_q.operand_load;
    assign reg_we_o        = (state_q == ST_WB) && !misaligned && writes_rd_i && !is_store_i;
    assign state_o         = state_q;
    assign pc_o            = pc_q;
    assign retire_count_o  = retire_q;
    assign halted_o        = state_q == ST_HALT;
    assign trap_o          = state_q == ST_TRAP;
    assign trap_cause_o    = cause_q;
endmodule
